call_request_latch: RTL and testbench
=====================================

# call_request_latch

Consumes the 12-bit pseudo-random press word from the press-pattern generator and turns it into the elevator's pending-call state. Samples the word at a fixed interval and decodes it into up-hall, down-hall and car calls for a 4-floor building. Latches the calls until the controller reports a floor served. Sits between the press generator and the elevator controller FSM.

## Interface
- INTERVAL, 16: cycles between samples of the press word; legal range 2..256.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state.
- en  input  1  enables the sample interval counter; low freezes it.
- randy  input  12  press word from the generator; bits [3:0] up calls, [7:4] down calls, [11:8] car calls; bit i of each field is floor i.
- serve_valid  input  1  controller has the car stopped with doors open this cycle.
- serve_floor  input  2  floor being served; qualified by serve_valid.
- serve_up  input  1  car departs upward from serve_floor; clears that floor's up call.
- serve_down  input  1  car departs downward from serve_floor; clears that floor's down call.
- up_req  output  4  pending up-hall calls.
- down_req  output  4  pending down-hall calls.
- car_req  output  4  pending car calls.
- any_req  output  1  OR of all 12 pending bits.
- new_req  output  1  one-cycle pulse when at least one pending bit goes 0->1.
- press_count  output  8  accepted new calls, saturating.

## Operation
- Interval counter `icnt`, log2(INTERVAL) bits, wide enough for INTERVAL-1:
  - resets to 0;
  - increments while en=1 and wraps from INTERVAL-1 to 0;
  - holds while en=0.
- Sample strobe: `samp` = en && icnt==INTERVAL-1.
- Masking on samp:
  - up-call bit 3 is forced 0 (no up from the top floor);
  - down-call bit 0 is forced 0 (no down from the ground floor).
  - The masked word is `m`.
- Service clear when serve_valid=1, with f = serve_floor:
  - car_req[f] is cleared;
  - up_req[f] is cleared if serve_up;
  - down_req[f] is cleared if serve_down;
  - if neither serve_up nor serve_down is set, both hall calls at f are cleared (idle stop).
- Next state per bit: (pending | (samp ? m : 0)) & ~clear. When set and clear hit the same bit in the same cycle, clear wins.
- new_req: registered; high in the cycle after an update in which any bit went 0->1. A re-press of an already-pending bit does not pulse.
- press_count: adds the popcount of 0->1 transitions in the cycle they occur; saturates at 255 and never wraps.
- any_req: combinational OR of the registered pending bits.

## Timing
- Reset values: up_req, down_req and car_req are 0; any_req=0, new_req=0, press_count=0, icnt=0.
- First samp occurs INTERVAL-1 cycles after rst deasserts with en=1 held.
- Latency: randy is sampled at the edge ending the samp cycle, and pending bits are visible the next cycle. new_req and the press_count update appear in that same cycle.
- Service clear takes effect on the edge ending the serve_valid cycle, so the cleared bits read 0 the next cycle.
- randy is only looked at during samp cycles; its value in other cycles is ignored.
- rst asserting mid-operation clears all state immediately, regardless of clk; no pending call survives.
- en falling during the samp cycle: no sample is taken and icnt holds at INTERVAL-1. The next cycle with en=1 is a samp.

## Test plan
- Reset, then 15 cycles with en=1 and randy=12'h421 -> at cycle 16: up_req=4'b0001, down_req=4'b0010, car_req=4'b0100, new_req pulses once, press_count=3.
- randy=12'hFFF at samp -> up_req=4'b0111, down_req=4'b1110, car_req=4'hF, press_count=10. Repeat 12'hFFF at the next samp -> no new_req, count stays 10.
- Pending up_req[2]=1 and car_req[2]=1; serve_valid=1, serve_floor=2, serve_up=1 -> the next cycle both are 0, down_req[2] is unchanged and any_req follows.
- serve_valid for floor 1 with serve_down=1 in the same cycle as a samp with randy=12'h220 -> car_req[1] and down_req[1] stay 0; new_req=0 if no other bit rose.
- Drive presses until press_count reaches 254, then accept 3 new calls -> press_count=255 and holds there.
- Assert rst low asynchronously mid-interval with calls pending -> all outputs are 0 without a clock edge. After release, the first samp occurs exactly INTERVAL-1 cycles later.

Source files
------------

// File: rtl/call_request_latch.sv
// Samples the generator's press word every INTERVAL cycles and keeps the
// pending up-hall, down-hall and car calls latched until the floor is served.
module call_request_latch #(
  parameter int unsigned INTERVAL = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] randy,
  input  logic        serve_valid,
  input  logic [1:0]  serve_floor,
  input  logic        serve_up,
  input  logic        serve_down,
  output logic [3:0]  up_req,
  output logic [3:0]  down_req,
  output logic [3:0]  car_req,
  output logic        any_req,
  output logic        new_req,
  output logic [7:0]  press_count
);

  localparam int unsigned CW    = $clog2(INTERVAL);
  localparam int unsigned NBITS = 12;
  localparam logic [CW-1:0]    ILAST    = CW'(INTERVAL - 1);
  // No up call from the top floor (up bit 3), no down call from the ground floor (down bit 0).
  localparam logic [NBITS-1:0] PRESS_MASK = 12'hFE7;

  logic [CW-1:0]    icnt;
  logic             samp;
  logic [NBITS-1:0] pend;
  logic [NBITS-1:0] set_bits;
  logic [NBITS-1:0] clr_bits;
  logic [NBITS-1:0] nxt_bits;
  logic [NBITS-1:0] rise_bits;
  logic [3:0]       floor_mask;
  logic [3:0]       rise_cnt;
  logic [8:0]       count_sum;
  logic [7:0]       count_nxt;

  assign pend    = {car_req, down_req, up_req};
  assign any_req = |pend;

  // Sample strobe, service clear and next pending state.
  always_comb begin
    samp       = en && (icnt == ILAST);
    set_bits   = samp ? (randy & PRESS_MASK) : '0;
    floor_mask = 4'(4'b0001 << serve_floor);
    clr_bits   = '0;
    if (serve_valid) begin
      clr_bits[11:8] = floor_mask;
      // An idle stop (neither direction flagged) clears both hall calls.
      clr_bits[7:4]  = (serve_down || !serve_up) ? floor_mask : 4'b0000;
      clr_bits[3:0]  = (serve_up || !serve_down) ? floor_mask : 4'b0000;
    end
    nxt_bits  = (pend | set_bits) & ~clr_bits;
    rise_bits = nxt_bits & ~pend;
  end

  // Saturating count of newly accepted calls.
  always_comb begin
    rise_cnt = 4'd0;
    for (int i = 0; i < int'(NBITS); i++) begin
      rise_cnt = rise_cnt + 4'(rise_bits[i]);
    end
    count_sum = 9'(press_count) + 9'(rise_cnt);
    count_nxt = count_sum[8] ? 8'hFF : count_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt        <= '0;
      up_req      <= '0;
      down_req    <= '0;
      car_req     <= '0;
      new_req     <= 1'b0;
      press_count <= '0;
    end else begin
      if (en) begin
        icnt <= (icnt == ILAST) ? '0 : icnt + CW'(1);
      end
      up_req      <= nxt_bits[3:0];
      down_req    <= nxt_bits[7:4];
      car_req     <= nxt_bits[11:8];
      new_req     <= |rise_bits;
      press_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_call_request_latch.sv
// Directed bench for call_request_latch with INTERVAL=16; the bench tracks the
// sample phase itself and compares against hand-computed call states.
module tb_call_request_latch;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] randy;
  logic        serve_valid;
  logic [1:0]  serve_floor;
  logic        serve_up;
  logic        serve_down;
  logic [3:0]  up_req;
  logic [3:0]  down_req;
  logic [3:0]  car_req;
  logic        any_req;
  logic        new_req;
  logic [7:0]  press_count;

  int errors = 0;
  int checks = 0;
  int ic     = 0;

  call_request_latch #(.INTERVAL(16)) dut (
    .clk(clk), .rst(rst), .en(en), .randy(randy),
    .serve_valid(serve_valid), .serve_floor(serve_floor),
    .serve_up(serve_up), .serve_down(serve_down),
    .up_req(up_req), .down_req(down_req), .car_req(car_req),
    .any_req(any_req), .new_req(new_req), .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, tracking the expected interval phase.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (rst && en) ic = (ic == 15) ? 0 : ic + 1;
      #1;
    end
  endtask

  task automatic goto_samp();
    for (int k = 0; k < 40 && ic != 15; k++) tick(1);
  endtask

  task automatic sample(input logic [11:0] word);
    randy = word;
    goto_samp();
    tick(1);
    randy = 12'h000;
  endtask

  task automatic clear_all();
    serve_up = 1'b0;
    serve_down = 1'b0;
    for (int f = 0; f < 4; f++) begin
      serve_valid = 1'b1;
      serve_floor = 2'(f);
      tick(1);
    end
    serve_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; randy = 12'h000;
    serve_valid = 1'b0; serve_floor = 2'd0; serve_up = 1'b0; serve_down = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("reset_pending", {car_req, down_req, up_req}, 12'h000);
    check("reset_any", 12'(any_req), 12'h0);
    check("reset_new", 12'(new_req), 12'h0);
    check("reset_count", 12'(press_count), 12'h000);

    // First sample: 15 cycles to reach samp, visible after the 16th edge.
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b1; randy = 12'h421; ic = 0;
    tick(15);
    check("pre_samp_up", 12'(up_req), 12'h0);
    check("pre_samp_new", 12'(new_req), 12'h0);
    tick(1);
    check("first_up", 12'(up_req), 12'h1);
    check("first_down", 12'(down_req), 12'h2);
    check("first_car", 12'(car_req), 12'h4);
    check("first_new", 12'(new_req), 12'h1);
    check("first_count", 12'(press_count), 12'd3);
    check("first_any", 12'(any_req), 12'h1);
    randy = 12'h000;
    tick(1);
    check("first_new_drop", 12'(new_req), 12'h0);

    // All presses, with masking of top-up and ground-down.
    sample(12'hFFF);
    check("fff_up", 12'(up_req), 12'h7);
    check("fff_down", 12'(down_req), 12'hE);
    check("fff_car", 12'(car_req), 12'hF);
    check("fff_count", 12'(press_count), 12'd10);
    check("fff_new", 12'(new_req), 12'h1);
    sample(12'hFFF);
    check("repress_new", 12'(new_req), 12'h0);
    check("repress_count", 12'(press_count), 12'd10);

    // Directional and idle service clears.
    serve_valid = 1'b1; serve_floor = 2'd2; serve_up = 1'b1;
    tick(1);
    check("serve2_up", 12'(up_req), 12'h3);
    check("serve2_car", 12'(car_req), 12'hB);
    check("serve2_down", 12'(down_req), 12'hE);
    check("serve2_any", 12'(any_req), 12'h1);
    serve_floor = 2'd1; serve_up = 1'b0;
    tick(1);
    check("idle1_all", {car_req, down_req, up_req}, 12'h9C1);
    serve_floor = 2'd3; serve_down = 1'b1;
    tick(1);
    check("serve3_down", {car_req, down_req, up_req}, 12'h141);
    serve_valid = 1'b0; serve_down = 1'b0;

    // Clear beats set when both hit floor 1 in the samp cycle.
    goto_samp();
    randy = 12'h220; serve_valid = 1'b1; serve_floor = 2'd1; serve_down = 1'b1;
    tick(1);
    serve_valid = 1'b0; serve_down = 1'b0; randy = 12'h000;
    check("collide_all", {car_req, down_req, up_req}, 12'h141);
    check("collide_new", 12'(new_req), 12'h0);
    check("collide_count", 12'(press_count), 12'd10);

    // Saturation of press_count.
    for (int r = 0; r < 24; r++) begin
      clear_all();
      sample(12'hFFF);
    end
    check("count_250", 12'(press_count), 12'd250);
    clear_all();
    sample(12'hF00);
    check("count_254", 12'(press_count), 12'd254);
    clear_all();
    sample(12'h007);
    check("count_sat", 12'(press_count), 12'd255);
    check("sat_new", 12'(new_req), 12'h1);
    clear_all();
    sample(12'hFFF);
    check("count_hold", 12'(press_count), 12'd255);

    // Asynchronous reset mid-interval with calls pending.
    tick(3);
    #2 rst = 1'b0;
    #1;
    check("async_pending", {car_req, down_req, up_req}, 12'h000);
    check("async_any", 12'(any_req), 12'h0);
    check("async_count", 12'(press_count), 12'h000);
    @(posedge clk); #1;
    rst = 1'b1; ic = 0; randy = 12'h001;
    tick(15);
    check("rel_pre_samp", 12'(up_req), 12'h0);
    tick(1);
    check("rel_first_samp", 12'(up_req), 12'h1);
    check("rel_count", 12'(press_count), 12'd1);

    // en dropping in the samp cycle defers the sample.
    randy = 12'h002;
    goto_samp();
    en = 1'b0;
    tick(3);
    check("en_low_hold", 12'(up_req), 12'h1);
    en = 1'b1;
    tick(1);
    check("en_resume_up", 12'(up_req), 12'h3);
    check("en_resume_count", 12'(press_count), 12'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
